// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encodings and a parameter legality check.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    function automatic bit uart_params_ok(int clks_per_bit, int data_bits, int parity, int stop_bits);
        return (clks_per_bit >= 4) && (data_bits >= 5) && (data_bits <= 9) &&
               (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
               (stop_bits >= 1) && (stop_bits <= 2);
    endfunction
endpackage

// File: rtl/uart_rx_engine.sv
// UART receiver: two-flop synchroniser, mid-bit sampling FSM, parity/framing error flags.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 sync1, sync2;
    rx_state_t            state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [BW-1:0]        bit_idx, bit_idx_d;
    logic                 stop_idx, stop_idx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 perr, perr_d, ferr, ferr_d, ferr_now;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d, perr_out_d, ferr_out_d;
    logic                 par_exp;

    assign par_exp = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            state         <= RX_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            shreg         <= '0;
            perr          <= 1'b0;
            ferr          <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            sync1         <= serial_in;
            sync2         <= sync1;
            state         <= state_d;
            cnt           <= cnt_d;
            bit_idx       <= bit_idx_d;
            stop_idx      <= stop_idx_d;
            shreg         <= shreg_d;
            perr          <= perr_d;
            ferr          <= ferr_d;
            rx_data       <= data_d;
            rx_valid      <= valid_d;
            rx_parity_err <= perr_out_d;
            rx_frame_err  <= ferr_out_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bit_idx_d  = bit_idx;
        stop_idx_d = stop_idx;
        shreg_d    = shreg;
        perr_d     = perr;
        ferr_d     = ferr;
        ferr_now   = ferr | ~sync2;
        data_d     = rx_data;
        valid_d    = 1'b0;
        perr_out_d = rx_parity_err;
        ferr_out_d = rx_frame_err;
        case (state)
            RX_IDLE: if (!sync2) begin
                // the detecting cycle counts as 0, so START begins at 1
                state_d    = RX_START;
                cnt_d      = CW'(1);
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
            end
            RX_START: if (cnt == CNT_HALF) begin
                cnt_d   = '0;
                state_d = sync2 ? RX_IDLE : RX_DATA;
            end else cnt_d = cnt + 1'b1;
            RX_DATA: if (cnt == CNT_LAST) begin
                cnt_d   = '0;
                shreg_d = {sync2, shreg[DATA_BITS-1:1]};
                if (bit_idx == BIT_LAST) begin
                    bit_idx_d = '0;
                    state_d   = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
                end else bit_idx_d = bit_idx + 1'b1;
            end else cnt_d = cnt + 1'b1;
            RX_PARITY: if (cnt == CNT_LAST) begin
                cnt_d   = '0;
                perr_d  = (sync2 != par_exp);
                state_d = RX_STOP;
            end else cnt_d = cnt + 1'b1;
            RX_STOP: if (cnt == CNT_LAST) begin
                cnt_d  = '0;
                ferr_d = ferr_now;
                if (stop_idx == 1'(STOP_BITS - 1)) begin
                    stop_idx_d = 1'b0;
                    valid_d    = 1'b1;
                    data_d     = shreg;
                    perr_out_d = perr;
                    ferr_out_d = ferr_now;
                    // a low stop may be a break; hold off until the line recovers
                    state_d    = ferr_now ? RX_WAIT_HIGH : RX_IDLE;
                end else stop_idx_d = 1'b1;
            end else cnt_d = cnt + 1'b1;
            RX_WAIT_HIGH: if (sync2) state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: transmit FSM with valid/ready handshake, loopback mux, RX engine.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] i_tx_byte,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx_done,
    output logic                 o_tx_serial,
    input  logic                 i_rx_serial,
    input  logic                 i_loopback,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    if (!uart_params_ok(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_params
        $error("uart_xcvr: illegal parameter combination");
    end

    tx_state_t            tx_state, tx_state_d;
    logic [CW-1:0]        tx_cnt, tx_cnt_d;
    logic [BW-1:0]        tx_idx, tx_idx_d;
    logic                 tx_stop, tx_stop_d;
    logic [DATA_BITS-1:0] tx_data, tx_data_d;
    logic                 tx_done_d, tx_line, tx_par, tx_bit_end, rx_line;

    assign tx_par      = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
    assign tx_bit_end  = (tx_cnt == CNT_LAST);
    assign o_tx_ready  = (tx_state == TX_IDLE);
    assign o_tx_serial = i_loopback ? 1'b1 : tx_line;
    assign rx_line     = i_loopback ? tx_line : i_rx_serial;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_stop   <= 1'b0;
            tx_data   <= '0;
            o_tx_done <= 1'b0;
        end else begin
            tx_state  <= tx_state_d;
            tx_cnt    <= tx_cnt_d;
            tx_idx    <= tx_idx_d;
            tx_stop   <= tx_stop_d;
            tx_data   <= tx_data_d;
            o_tx_done <= tx_done_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_idx_d   = tx_idx;
        tx_stop_d  = tx_stop;
        tx_data_d  = tx_data;
        tx_done_d  = 1'b0;
        tx_line    = 1'b1;
        if (tx_state != TX_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            TX_IDLE: if (i_tx_valid) begin
                tx_data_d  = i_tx_byte;
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
                tx_stop_d  = 1'b0;
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_data[tx_idx];
                if (tx_bit_end) begin
                    if (tx_idx == BIT_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end else tx_idx_d = tx_idx + 1'b1;
                end
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_bit_end) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_stop == 1'(STOP_BITS - 1)) begin
                    tx_stop_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                    tx_done_d  = 1'b1;
                end else tx_stop_d = 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    uart_rx_engine #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY),
        .STOP_BITS    (STOP_BITS)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (rx_line),
        .rx_data       (o_rx_data),
        .rx_valid      (o_rx_valid),
        .rx_parity_err (o_rx_parity_err),
        .rx_frame_err  (o_rx_frame_err)
    );
endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr: 8N1, 8E1-loopback and 7O2 instances at 16 clocks per bit,
// a line-level frame model and a scoreboard of expected received frames.
module tb_uart_xcvr;
    localparam int CPB = 16;

    logic clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;
    logic reset;

    logic [7:0] a_tx_byte, a_rx_data;
    logic a_tx_valid, a_tx_ready, a_tx_done, a_tx_serial, a_rx_serial, a_loopback;
    logic a_rx_valid, a_perr, a_ferr;
    logic [7:0] b_tx_byte, b_rx_data;
    logic b_tx_valid, b_tx_ready, b_tx_done, b_tx_serial, b_rx_serial, b_loopback;
    logic b_rx_valid, b_perr, b_ferr;
    logic [6:0] c_tx_byte, c_rx_data;
    logic c_tx_valid, c_tx_ready, c_tx_done, c_tx_serial, c_rx_serial, c_loopback;
    logic c_rx_valid, c_perr, c_ferr;

    uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk_tb), .reset(reset), .i_tx_byte(a_tx_byte), .i_tx_valid(a_tx_valid),
        .o_tx_ready(a_tx_ready), .o_tx_done(a_tx_done), .o_tx_serial(a_tx_serial),
        .i_rx_serial(a_rx_serial), .i_loopback(a_loopback), .o_rx_data(a_rx_data),
        .o_rx_valid(a_rx_valid), .o_rx_parity_err(a_perr), .o_rx_frame_err(a_ferr));
    uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk_tb), .reset(reset), .i_tx_byte(b_tx_byte), .i_tx_valid(b_tx_valid),
        .o_tx_ready(b_tx_ready), .o_tx_done(b_tx_done), .o_tx_serial(b_tx_serial),
        .i_rx_serial(b_rx_serial), .i_loopback(b_loopback), .o_rx_data(b_rx_data),
        .o_rx_valid(b_rx_valid), .o_rx_parity_err(b_perr), .o_rx_frame_err(b_ferr));
    uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk(clk_tb), .reset(reset), .i_tx_byte(c_tx_byte), .i_tx_valid(c_tx_valid),
        .o_tx_ready(c_tx_ready), .o_tx_done(c_tx_done), .o_tx_serial(c_tx_serial),
        .i_rx_serial(c_rx_serial), .i_loopback(c_loopback), .o_rx_data(c_rx_data),
        .o_rx_valid(c_rx_valid), .o_rx_parity_err(c_perr), .o_rx_frame_err(c_ferr));

    typedef struct packed {
        logic [1:0] id;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    typedef struct {
        int         which;
        logic [8:0] data;
        int         nbits;
        int         par;
        int         nstop;
        bit         bad_par;
        bit         low_stop;
        logic [8:0] exp_d;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    frame_t obs_q[$];
    frame_t exp_q[$];
    bit     b_low_seen = 1'b0;
    int     checks = 0;
    int     errors = 0;

    // RX output monitor: every valid pulse becomes one observed frame
    always @(negedge clk_tb) begin
        if (a_rx_valid) obs_q.push_back('{2'd0, {1'b0, a_rx_data}, a_perr, a_ferr});
        if (b_rx_valid) obs_q.push_back('{2'd1, {1'b0, b_rx_data}, b_perr, b_ferr});
        if (c_rx_valid) obs_q.push_back('{2'd2, {2'b0, c_rx_data}, c_perr, c_ferr});
        if (b_tx_serial === 1'b0) b_low_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) a_rx_serial = v;
        else c_rx_serial = v;
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int par, input int nstop, input bit bad_par, input bit low_stop);
        logic p;
        set_line(which, 1'b0);
        repeat (CPB) @(negedge clk_tb);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            set_line(which, data[i]);
            p ^= data[i];
            repeat (CPB) @(negedge clk_tb);
        end
        if (par != 0) begin
            if (par == 1) p = ~p;
            if (bad_par) p = ~p;
            set_line(which, p);
            repeat (CPB) @(negedge clk_tb);
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(which, !(low_stop && s == nstop - 1));
            repeat (CPB) @(negedge clk_tb);
        end
        set_line(which, 1'b1);
        repeat (2 * CPB) @(negedge clk_tb);
    endtask

    task automatic drain(input string tag);
        frame_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s rx_valid: got none, expected frame %0h", tag, e.d);
            end else begin
                o = obs_q.pop_front();
                chk({tag, " source"}, 32'(o.id), 32'(e.id));
                chk({tag, " data"}, 32'(o.d), 32'(e.d));
                chk({tag, " parity_err"}, 32'(o.pe), 32'(e.pe));
                chk({tag, " frame_err"}, 32'(o.fe), 32'(e.fe));
            end
        end
        chk({tag, " extra rx_valid"}, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    task automatic wait_done(input int which, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk_tb);
            n++;
        end while (!((which == 0) ? a_tx_done : b_tx_done) && n < maxc);
    endtask

    initial begin
        vec_t       vt[6];
        logic [9:0] fr;
        logic [1:0] seen;
        int         n, busy_bad;

        vt[0] = '{0, 9'h03C, 8, 0, 1, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0};
        vt[1] = '{0, 9'h0FF, 8, 0, 1, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0};
        vt[2] = '{2, 9'h055, 7, 1, 2, 1'b1, 1'b0, 9'h055, 1'b1, 1'b0};
        vt[3] = '{2, 9'h02A, 7, 1, 2, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b1};
        vt[4] = '{2, 9'h07F, 7, 1, 2, 1'b0, 1'b0, 9'h07F, 1'b0, 1'b0};
        vt[5] = '{0, 9'h001, 8, 0, 1, 1'b0, 1'b1, 9'h001, 1'b0, 1'b1};

        reset = 1'b1;
        a_tx_byte = '0; a_tx_valid = 1'b0; a_rx_serial = 1'b1; a_loopback = 1'b0;
        b_tx_byte = '0; b_tx_valid = 1'b0; b_rx_serial = 1'b0; b_loopback = 1'b1;
        c_tx_byte = '0; c_tx_valid = 1'b0; c_rx_serial = 1'b1; c_loopback = 1'b0;
        repeat (3) @(negedge clk_tb);
        reset = 1'b0;
        @(negedge clk_tb);
        chk("reset tx_serial", 32'(a_tx_serial), 32'd1);
        chk("reset tx_ready", 32'(a_tx_ready), 32'd1);
        chk("reset tx_done", 32'(a_tx_done), 32'd0);
        chk("reset rx outputs", 32'({a_rx_valid, a_rx_data, a_perr, a_ferr}), 32'd0);

        // 8N1 transmit of 0xA5, cycle-exact line shape
        a_tx_byte = 8'hA5; a_tx_valid = 1'b1;
        @(negedge clk_tb);
        a_tx_valid = 1'b0;
        fr = {1'b1, 8'hA5, 1'b0};
        busy_bad = 0;
        for (int k = 0; k < 10; k++) begin
            seen = 2'b00;
            for (int c = 0; c < CPB; c++) begin
                if (a_tx_serial === 1'b1) seen[1] = 1'b1;
                else seen[0] = 1'b1;
                if (a_tx_ready !== 1'b0 || a_tx_done !== 1'b0) busy_bad++;
                @(negedge clk_tb);
            end
            chk($sformatf("8N1 A5 bit %0d line", k), 32'(seen), fr[k] ? 32'd2 : 32'd1);
        end
        chk("8N1 ready/done during frame", 32'(busy_bad), 32'd0);
        chk("8N1 done at 160", 32'(a_tx_done), 32'd1);
        chk("8N1 ready with done", 32'(a_tx_ready), 32'd1);
        @(negedge clk_tb);
        chk("8N1 done one cycle", 32'(a_tx_done), 32'd0);

        // receive vectors on the 8N1 and 7O2 instances
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{2'(vt[i].which), vt[i].exp_d, vt[i].exp_pe, vt[i].exp_fe});
            send_frame(vt[i].which, vt[i].data, vt[i].nbits, vt[i].par, vt[i].nstop,
                       vt[i].bad_par, vt[i].low_stop);
            drain($sformatf("vec%0d", i));
        end

        // 8E1 loopback, back-to-back 0x37 then 0x00
        exp_q.push_back('{2'd1, 9'h037, 1'b0, 1'b0});
        exp_q.push_back('{2'd1, 9'h000, 1'b0, 1'b0});
        b_low_seen = 1'b0;
        b_tx_byte = 8'h37; b_tx_valid = 1'b1;
        @(negedge clk_tb);
        b_tx_valid = 1'b0;
        wait_done(1, 400, n);
        chk("8E1 first frame length", 32'(n), 32'd176);
        chk("8E1 ready in done cycle", 32'(b_tx_ready), 32'd1);
        b_tx_byte = 8'h00; b_tx_valid = 1'b1;
        @(negedge clk_tb);
        b_tx_valid = 1'b0;
        chk("8E1 accept in done cycle", 32'(b_tx_ready), 32'd0);
        wait_done(1, 400, n);
        chk("8E1 second frame length", 32'(n), 32'd176);
        repeat (2 * CPB) @(negedge clk_tb);
        chk("8E1 loopback line stays high", 32'(b_low_seen), 32'd0);
        drain("8E1 loopback");

        // 5-cycle glitch must not start a frame
        a_rx_serial = 1'b0;
        repeat (5) @(negedge clk_tb);
        a_rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clk_tb);
        chk("glitch no rx_valid", 32'(obs_q.size()), 32'd0);
        exp_q.push_back('{2'd0, 9'h0C3, 1'b0, 1'b0});
        send_frame(0, 9'h0C3, 8, 0, 1, 1'b0, 1'b0);
        drain("after glitch");

        // break: 30 bit times low gives a single errored frame
        a_rx_serial = 1'b0;
        repeat (30 * CPB) @(negedge clk_tb);
        a_rx_serial = 1'b1;
        exp_q.push_back('{2'd0, 9'h000, 1'b0, 1'b1});
        repeat (2 * CPB) @(negedge clk_tb);
        drain("break");
        exp_q.push_back('{2'd0, 9'h081, 1'b0, 1'b0});
        send_frame(0, 9'h081, 8, 0, 1, 1'b0, 1'b0);
        drain("after break");

        // reset with both directions mid-data
        a_tx_byte = 8'hE7; a_tx_valid = 1'b1; a_rx_serial = 1'b0;
        @(negedge clk_tb);
        a_tx_valid = 1'b0;
        repeat (40) @(negedge clk_tb);
        reset = 1'b1;
        @(negedge clk_tb);
        chk("mid-frame reset tx_serial", 32'(a_tx_serial), 32'd1);
        chk("mid-frame reset tx_ready", 32'(a_tx_ready), 32'd1);
        chk("mid-frame reset rx outputs", 32'({a_tx_done, a_rx_valid, a_rx_data, a_perr, a_ferr}), 32'd0);
        reset = 1'b0; a_rx_serial = 1'b1;
        busy_bad = 0;
        for (int c = 0; c < 3 * CPB; c++) begin
            @(negedge clk_tb);
            if (a_tx_done !== 1'b0) busy_bad++;
        end
        chk("no done after reset", 32'(busy_bad), 32'd0);
        drain("reset partial");
        a_loopback = 1'b1;
        exp_q.push_back('{2'd0, 9'h05A, 1'b0, 1'b0});
        a_tx_byte = 8'h5A; a_tx_valid = 1'b1;
        @(negedge clk_tb);
        a_tx_valid = 1'b0;
        wait_done(0, 400, n);
        chk("post-reset 8N1 frame length", 32'(n), 32'd160);
        repeat (2 * CPB) @(negedge clk_tb);
        drain("post-reset 5A");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
